// File: rtl/obi_mem_pkg.sv
// Shared types for the OBI memory responder: grant-state encoding,
// the error read-data pattern and the response-pipe entry.
package obi_mem_pkg;

  // Grant FSM states: IDLE grants immediately, STALL counts out the grant delay.
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } gnt_state_e;

  // Read data returned with an error response.
  localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;

  // One in-flight response.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

endpackage

// File: rtl/obi_mem_resp_pipe.sv
// Fixed-latency response shift pipe. Every pushed entry appears at the head
// exactly DEPTH cycles later; responses can never stall.
module obi_mem_resp_pipe
  import obi_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  resp_t push,
  output resp_t head,
  output logic  retire
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] err_q;
  logic [31:0]      data_q [DEPTH];

  // Control bits shift with reset so a reset drops every pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q[0] <= push.valid;
      err_q[0]   <= push.err;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  // Payload shifts without reset; it is masked by the valid bit at the head.
  always_ff @(posedge clk) begin
    data_q[0] <= push.rdata;
    for (int i = 1; i < int'(DEPTH); i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign head.valid = valid_q[DEPTH-1];
  assign head.err   = valid_q[DEPTH-1] & err_q[DEPTH-1];
  assign head.rdata = valid_q[DEPTH-1] ? data_q[DEPTH-1] : 32'h0;
  assign retire     = valid_q[DEPTH-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI subordinate memory: grant FSM with optional grant delay, outstanding
// limit, word-addressed SRAM and fixed-latency in-order responses.
// Optional feature macro: OBI_MEM_ERR_EN (adds err_o and out-of-range errors;
// without it out-of-range addresses wrap modulo MEM_WORDS).
module obi_mem_responder
  import obi_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 16384,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = ""
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
`ifdef OBI_MEM_ERR_EN
  output logic        err_o,
`endif
  output logic [31:0] rdata_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0] mem [MEM_WORDS];

  gnt_state_e  state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [OW-1:0] outstanding;
  logic          gnt;
  logic          room;
  logic          retire;
  logic          addr_err;
  logic [AW-1:0] idx;
  resp_t         push;
  resp_t         head;

  assign idx = addr_i[AW+1:2];

`ifdef OBI_MEM_ERR_EN
  // Any set bit above the word index means the word is past the array.
  assign addr_err = |addr_i[31:AW+2];
  assign err_o    = head.err;
  logic unused_bits;
  assign unused_bits = ^addr_i[1:0];
`else
  assign addr_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:AW+2], addr_i[1:0], head.err};
`endif

  // A slot is free below the limit, or at the limit when one retires now.
  assign room = (outstanding < OW'(MAX_OUTSTANDING)) || retire;

  // Grant state and delay counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and grant decode; dropping req while stalled returns to IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gnt        = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (GNT_DELAY == 0) begin
            gnt = room;
          end else begin
            state_next = STALL;
            cnt_next   = CW'(1);
          end
        end
      end
      STALL: begin
        if (!req_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt < CW'(GNT_DELAY)) begin
          cnt_next = cnt + 1'b1;
        end else if (room) begin
          gnt        = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign gnt_o = gnt & rst_ni;

  // Outstanding count: grant adds, retire removes, both together hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({gnt_o, retire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Byte-lane write on the grant edge; erroring writes are dropped.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // The read word is captured into the first pipe stage on the grant edge.
  assign push.valid = gnt_o;
  assign push.err   = addr_err;
  assign push.rdata = addr_err ? ERR_RDATA : (we_i ? 32'h0 : mem[idx]);

  obi_mem_resp_pipe #(
    .DEPTH (RESP_LATENCY)
  ) u_resp_pipe (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .push   (push),
    .head   (head),
    .retire (retire)
  );

  assign rvalid_o = head.valid;
  assign rdata_o  = head.rdata;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three instances with different grant delay,
// latency and size; table-driven transactions, hand sequences for stall,
// outstanding limit and reset flush, and random traffic against a model.
module tb_obi_mem_responder;

`ifdef OBI_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [31:0] ERR_WORD = 32'hBADCAB1E;

  logic clk;
  logic rst_n;
  logic        req    [3];
  logic        we     [3];
  logic [31:0] addr   [3];
  logic [3:0]  be     [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [31:0] rdata  [3];

  obi_mem_responder #(.MEM_WORDS(16384), .GNT_DELAY(0), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
`ifdef OBI_MEM_ERR_EN
    .err_o(err[0]),
`endif
    .rdata_o(rdata[0]));

  obi_mem_responder #(.MEM_WORDS(1024), .GNT_DELAY(3), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
`ifdef OBI_MEM_ERR_EN
    .err_o(err[1]),
`endif
    .rdata_o(rdata[1]));

  obi_mem_responder #(.MEM_WORDS(1024), .GNT_DELAY(0), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
    .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
`ifdef OBI_MEM_ERR_EN
    .err_o(err[2]),
`endif
    .rdata_o(rdata[2]));

`ifndef OBI_MEM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
  assign err[2] = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance configuration as seen by the model.
  function automatic int unsigned mwords(int k);
    return (k == 0) ? 16384 : 1024;
  endfunction
  function automatic int gdel(int k);
    return (k == 1) ? 3 : 0;
  endfunction
  function automatic int lat(int k);
    return (k == 2) ? 3 : 1;
  endfunction
  localparam int MAXO = 2;

  // Reference model: memory image per instance plus a queue of promised responses.
  typedef struct {
    int          due;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t        q [$];
  logic [31:0] mmem [3][16384];
  int          mcyc;
  int          wcnt;

  int checks;
  int errors;
  logic        obs_gnt, obs_rvalid, obs_err;
  logic [31:0] obs_rdata;

  typedef struct {
    int          k;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;
  vec_t tbl [9];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, mcyc, act, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s cycle=%0d actual=timeout required=event", name, mcyc);
  endtask

  // One clock cycle of the model for the active instance k.
  task automatic model(int k);
    bit          due, room, eg, oor;
    logic [31:0] wa;
    int          widx;
    due  = (q.size() > 0) && (q[0].due == mcyc);
    room = (q.size() < MAXO) || due;
    eg   = req[k] && (wcnt >= gdel(k)) && room;
    check("gnt", {31'b0, gnt[k]}, {31'b0, eg});
    check("rvalid", {31'b0, rvalid[k]}, {31'b0, due});
    if (due) begin
      check("rdata", rdata[k], q[0].rdata);
      check("err", {31'b0, err[k]}, {31'b0, q[0].err});
      void'(q.pop_front());
    end else begin
      check("rdata_idle", rdata[k], 32'h0);
      check("err_idle", {31'b0, err[k]}, 32'h0);
    end
    if (eg) begin
      wa   = {2'b00, addr[k][31:2]};
      oor  = ERR_EN && (wa >= mwords(k));
      widx = int'(wa % mwords(k));
      if (we[k]) begin
        if (!oor)
          for (int b = 0; b < 4; b++)
            if (be[k][b]) mmem[k][widx][8*b +: 8] = wdata[k][8*b +: 8];
        q.push_back('{due: mcyc + lat(k), rdata: oor ? ERR_WORD : 32'h0, err: oor});
      end else begin
        q.push_back('{due: mcyc + lat(k), rdata: oor ? ERR_WORD : mmem[k][widx], err: oor});
      end
    end
    wcnt = (!req[k] || eg) ? 0 : wcnt + 1;
    mcyc++;
    obs_gnt    = gnt[k];
    obs_rvalid = rvalid[k];
    obs_rdata  = rdata[k];
    obs_err    = err[k];
  endtask

  task automatic step(int k, bit r, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    @(posedge clk);
    #1;
    req[k] = r; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    @(negedge clk);
    model(k);
  endtask

  // Single transaction: hold req until granted, then idle until the response.
  task automatic do_txn(vec_t v);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step(v.k, 1'b1, v.we, v.addr, v.be, v.wdata);
      got = obs_gnt;
    end
    if (!got) timeout("txn_gnt");
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step(v.k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      got = obs_rvalid;
    end
    if (!got) timeout("txn_rvalid");
    else begin
      check("tbl_rdata", obs_rdata, v.exp_rdata);
      check("tbl_err", {31'b0, obs_err}, {31'b0, v.exp_err});
    end
  endtask

  task automatic idle(int k, int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr(int k);
    logic [31:0] base;
    int sel;
    sel = int'($urandom_range(0, 3));
    case (sel)
      2:       base = 32'(mwords(k)) << 2;
      3:       base = 32'h8000_0000;
      default: base = 32'h0;
    endcase
    return base | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", mcyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] g_exp;
    logic [9:0] v_exp;
    int         ng;
    vec_t       v;

    checks = 0; errors = 0; mcyc = 0; wcnt = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
    end

    tbl[0] = '{0, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1] = '{0, 1'b0, 32'h1000, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{0, 1'b1, 32'h2000, 4'hF, 32'h11223344, 32'h0, 1'b0};
    tbl[3] = '{0, 1'b1, 32'h2000, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0};
    tbl[4] = '{0, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h11BB33DD, 1'b0};
    tbl[5] = '{1, 1'b1, 32'h0000, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0};
    tbl[6] = '{1, 1'b0, 32'h1000, 4'hF, 32'h0, ERR_EN ? ERR_WORD : 32'hCAFEF00D, ERR_EN};
    tbl[7] = '{1, 1'b1, 32'h1000, 4'hF, 32'h55555555, ERR_EN ? ERR_WORD : 32'h0, ERR_EN};
    tbl[8] = '{1, 1'b0, 32'h0000, 4'hF, 32'h0, ERR_EN ? 32'hCAFEF00D : 32'h55555555, 1'b0};

    // Outputs idle while reset is held.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_gnt", {31'b0, gnt[k]}, 32'h0);
      check("rst_rvalid", {31'b0, rvalid[k]}, 32'h0);
      check("rst_rdata", rdata[k], 32'h0);
      check("rst_err", {31'b0, err[k]}, 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed transaction table.
    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i]);
      $display("txn %0d: inst=%0d we=%0d addr=%h rdata=%h err=%0d", i, tbl[i].k, tbl[i].we,
               tbl[i].addr, obs_rdata, obs_err);
    end

    // Random traffic per instance after preloading the words it touches.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 16; w++) begin
        v = '{k, 1'b1, 32'(w) << 2, 4'hF, $urandom, 32'h0, 1'b0};
        do_txn(v);
      end
      for (int i = 0; i < 300; i++)
        step(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(k),
             4'($urandom_range(0, 15)), $urandom);
      idle(k, 6);
      check("drained", 32'(q.size()), 32'h0);
      $display("random phase inst=%0d done, errors so far=%0d", k, errors);
    end

    // Grant delay 3: held request is granted on its 4th cycle.
    for (int i = 0; i < 4; i++) begin
      step(1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
      check("t3_gnt", {31'b0, obs_gnt}, (i == 3) ? 32'h1 : 32'h0);
    end
    step(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("t3_rvalid", {31'b0, obs_rvalid}, 32'h1);
    idle(1, 2);
    $display("grant delay sequence done");

    // Latency 3, two outstanding: grants at 0,1,3,4 and responses at 3,4,6,7.
    g_exp = 10'b00_0001_1011;
    v_exp = 10'b00_1101_1000;
    ng = 0;
    for (int c = 0; c < 10; c++) begin
      step(2, ng < 4, 1'b0, 32'(ng + 1) << 2, 4'hF, 32'h0);
      check("t4_gnt", {31'b0, obs_gnt}, {31'b0, g_exp[c]});
      check("t4_rvalid", {31'b0, obs_rvalid}, {31'b0, v_exp[c]});
      if (obs_gnt) ng++;
    end
    $display("outstanding-limit sequence done, grants=%0d", ng);

    // Reset with two responses in flight drops them.
    step(2, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
    step(2, 1'b1, 1'b0, 32'hC, 4'hF, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst_n  = 1'b0;
      req[2] = 1'b0;
      @(negedge clk);
      check("t5_rst_rvalid", {31'b0, rvalid[2]}, 32'h0);
      check("t5_rst_gnt", {31'b0, gnt[2]}, 32'h0);
    end
    q.delete();
    wcnt  = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      check("t5_no_rvalid", {31'b0, obs_rvalid}, 32'h0);
    end
    $display("reset flush sequence done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
